// File: rtl/uart_rx.sv
// uart_rx -- 8-bit asynchronous serial receiver with a one-byte holding buffer.
//
// Frame: 1 start bit (low), 8 data bits LSB first, optional even-parity bit,
// 1 stop bit (high). The line is oversampled by a bit-period counter; the
// start bit is confirmed at its centre and every later bit is sampled one
// full bit period after the previous sample.
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after
// the data bits. Without it the frame is 1 start, 8 data, 1 stop.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   rxd          in   asynchronous serial line, idle high
//   rx_clear     in   one-cycle acknowledge of the buffered byte; also clears
//                     the sticky error flags
//   rx_ready     out  an unacknowledged byte is held on rx_data
//   rx_data      out  last delivered byte
//   rx_overrun   out  sticky: a byte was delivered while rx_ready was high
//   rx_frame_err out  sticky: bad stop bit (or bad parity)
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_clear,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_wait_high;  // set after a low stop bit: ignore the line until it idles high
  logic        r_par_bad;
  logic        r_ready;
  logic [7:0]  r_data;
  logic        r_overrun;
  logic        r_frame_err;
  logic        w_rxd_s;

`ifdef UART_RX_PARITY_EN
  // Even parity: data XOR parity bit must be zero for a good frame.
  function automatic logic parity_bad(input logic [7:0] data, input logic par_bit);
    parity_bad = (^data) ^ par_bit;
  endfunction
`endif

  assign w_rxd_s = r_sync2;

  // Synchronizer, receive FSM and the output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_cnt       <= 16'd0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_wait_high <= 1'b0;
      r_par_bad   <= 1'b0;
      r_ready     <= 1'b0;
      r_data      <= 8'h00;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;

      // Acknowledge first; set events further down override it (set wins).
      if (rx_clear) begin
        r_ready     <= 1'b0;
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_wait_high) begin
            if (w_rxd_s) begin
              r_wait_high <= 1'b0;
            end
          end else if (!w_rxd_s) begin
            r_state <= S_START;
            r_cnt   <= 16'd0;
          end
        end

        S_START: begin
          if (r_cnt == HALF_BIT) begin
            r_cnt <= 16'd0;
            r_idx <= 3'd0;
            // A start bit that is already high again at its centre is a glitch.
            r_state <= w_rxd_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (r_cnt == FULL_BIT) begin
            r_shift <= {w_rxd_s, r_shift[7:1]};
            r_cnt   <= 16'd0;
            r_idx   <= r_idx + 3'd1;
            r_par_bad <= 1'b0;
            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == FULL_BIT) begin
            r_par_bad <= parity_bad(r_shift, w_rxd_s);
            r_cnt     <= 16'd0;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`endif

        S_STOP: begin
          if (r_cnt == FULL_BIT) begin
            r_cnt   <= 16'd0;
            r_state <= S_IDLE;
            if (w_rxd_s && !r_par_bad) begin
              r_data  <= r_shift;
              r_ready <= 1'b1;
              // A coincident acknowledge consumes the old byte, so no overrun.
              if (r_ready && !rx_clear) begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              if (!w_rxd_s) begin
                r_wait_high <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 16'd0;
        end
      endcase
    end
  end

  assign rx_ready     = r_ready;
  assign rx_data      = r_data;
  assign rx_overrun   = r_overrun;
  assign rx_frame_err = r_frame_err;

endmodule
